// File: rtl/seg_display_scanner.sv
// Time-multiplexed 7-segment scanner: one shared external BCD decoder, blanking gaps
// between digits, and a double-buffered display word committed at frame boundaries.
module seg_display_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  output logic [3:0]              bcd,
  input  logic [6:0]              segment_in,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    pending,
  output logic                    frame_done,
  output logic                    bcd_err
);

  // state | meaning
  // BLANK | all digits off for BLANK_CYCLES cycles, decoder settles on next digit
  // SHOW  | digit idx enabled for REFRESH_DIV cycles, segments refreshed each cycle
  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_E      = 7'b1001111;

  logic [4*NUM_DIGITS-1:0] active;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [IW-1:0]           idx;
  logic [CW-1:0]           cnt;
  logic [0:0]              state;

  logic                    phase_end;
  logic [0:0]              state_nxt;
  logic                    boundary;
  logic                    digit_err;
  logic                    lz_hit;
  logic                    zero_above;
  logic [6:0]              seg_sel;
  logic [NUM_DIGITS-1:0]   an_sel;

  always_comb begin
    if (state == ST_BLANK) phase_end = (cnt == BLANK_LAST);
    else                   phase_end = (cnt == SHOW_LAST);
    state_nxt = phase_end ? ~state : state;
    boundary  = (state == ST_SHOW) && phase_end && (idx == IDX_LAST);
  end

  always_comb begin
    bcd    = 4'd0;
    an_sel = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        bcd       = active[4*i +: 4];
        an_sel[i] = 1'b1;
      end
    end
  end

  // Walk from the most significant digit down so zero_above covers digit i and everything above it.
  always_comb begin
    zero_above = 1'b1;
    lz_hit     = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (active[4*i +: 4] == 4'd0);
      if ((i > 0) && (idx == IW'(i))) lz_hit = zero_above;
    end
  end

  always_comb begin
    digit_err = (bcd > 4'd9);
    if (digit_err)               seg_sel = SEG_E;
    else if (blank_lz && lz_hit) seg_sel = 7'b0;
    else                         seg_sel = segment_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= phase_end ? '0 : cnt + CW'(1);
      if ((state == ST_SHOW) && phase_end)
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end
  end

  // Outputs follow the next state so an and seg switch on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= '0;
      seg        <= '0;
      bcd_err    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (state_nxt == ST_SHOW) begin
        an      <= an_sel;
        seg     <= seg_sel;
        bcd_err <= digit_err;
      end else begin
        an      <= '0;
        seg     <= '0;
        bcd_err <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else if (load && boundary) begin
      active  <= value;
      shadow  <= value;
      pending <= 1'b0;
    end else begin
      if (boundary && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end
      if (load) begin
        shadow  <= value;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner with 4 digits, 4-cycle show, 2-cycle blank.
module tb_seg_display_scanner;

  localparam int ND = 4;
  localparam int FRAME = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic [3:0]  bcd;
  logic [6:0]  segment_in;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        pending;
  logic        frame_done;
  logic        bcd_err;

  int checks   = 0;
  int failures = 0;
  int k;

  seg_display_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(4), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .blank_lz(blank_lz),
    .bcd(bcd), .segment_in(segment_in), .seg(seg), .an(an),
    .pending(pending), .frame_done(frame_done), .bcd_err(bcd_err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] b);
    case (b)
      4'd0: dec = 7'b1111110;
      4'd1: dec = 7'b0110000;
      4'd2: dec = 7'b1101101;
      4'd3: dec = 7'b1111001;
      4'd4: dec = 7'b0110011;
      4'd5: dec = 7'b1011011;
      4'd6: dec = 7'b1011111;
      4'd7: dec = 7'b1110000;
      4'd8: dec = 7'b1111111;
      4'd9: dec = 7'b1111011;
      default: dec = 7'b0000000;
    endcase
  endfunction

  assign segment_in = dec(bcd);

  // Cycles since reset release; the expected scan position is derived from this alone.
  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  typedef struct {
    logic [15:0] value;
    logic        lz;
    logic [27:0] segs;
    logic [3:0]  errm;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [27:0] mk(input logic [6:0] s0, input logic [6:0] s1,
                                     input logic [6:0] s2, input logic [6:0] s3);
    mk = {s3, s2, s1, s0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d actual=%h required=%h", name, k, act, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input logic [27:0] segs,
                             input logic [3:0] errm, input logic [15:0] word);
    int d;
    int pos;
    logic show;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_err;
    d    = (k % FRAME) / 6;
    pos  = k % 6;
    show = (pos >= 2);
    e_an  = show ? (4'b0001 << d) : 4'b0000;
    e_seg = show ? segs[7*d +: 7] : 7'b0;
    e_err = show ? errm[d] : 1'b0;
    chk({tag, ".an"},         32'(an),         32'(e_an));
    chk({tag, ".seg"},        32'(seg),        32'(e_seg));
    chk({tag, ".bcd_err"},    32'(bcd_err),    32'(e_err));
    chk({tag, ".bcd"},        32'(bcd),        32'(word[4*d +: 4]));
    chk({tag, ".frame_done"}, 32'(frame_done), 32'((k % FRAME == 0) && (k != 0)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [27:0] zeros;
  logic [27:0] prev_segs;
  logic [3:0]  prev_errm;
  logic [15:0] prev_word;
  logic [27:0] s4321;
  logic [27:0] s9999;

  initial begin
    zeros = mk(7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110);
    s4321 = mk(7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011);
    s9999 = mk(7'b1111011, 7'b1111011, 7'b1111011, 7'b1111011);
    vecs[0] = '{16'h1234, 1'b0, mk(7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000), 4'b0000};
    vecs[1] = '{16'h0050, 1'b1, mk(7'b1111110, 7'b1011011, 7'b0000000, 7'b0000000), 4'b0000};
    vecs[2] = '{16'h00A7, 1'b0, mk(7'b1110000, 7'b1001111, 7'b1111110, 7'b1111110), 4'b0010};
    vecs[3] = '{16'h0000, 1'b1, mk(7'b1111110, 7'b0000000, 7'b0000000, 7'b0000000), 4'b0000};
    vecs[4] = '{16'h8005, 1'b1, mk(7'b1011011, 7'b1111110, 7'b1111110, 7'b1111111), 4'b0000};
    vecs[5] = '{16'hF000, 1'b1, mk(7'b1111110, 7'b1111110, 7'b1111110, 7'b1001111), 4'b1000};

    rst = 1'b1; load = 1'b0; value = 16'h0; blank_lz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.an", 32'(an), 32'(0));
    chk("rst.seg", 32'(seg), 32'(0));
    chk("rst.pending", 32'(pending), 32'(0));
    chk("rst.frame_done", 32'(frame_done), 32'(0));
    chk("rst.bcd", 32'(bcd), 32'(0));
    chk("rst.bcd_err", 32'(bcd_err), 32'(0));
    rst = 1'b0;

    // Two idle frames showing "0000".
    for (int i = 0; i < 2 * FRAME; i++) begin
      check_cycle("idle", zeros, 4'b0000, 16'h0000);
      step();
    end

    prev_segs = zeros; prev_errm = 4'b0000; prev_word = 16'h0000;
    for (int v = 0; v < 6; v++) begin
      for (int g = 0; g < FRAME && (k % FRAME) != 10; g++) begin
        check_cycle("pre", prev_segs, prev_errm, prev_word);
        step();
      end
      check_cycle("pre", prev_segs, prev_errm, prev_word);
      load = 1'b1; value = vecs[v].value;
      step();
      load = 1'b0;
      for (int g = 0; g < FRAME && (k % FRAME) != 0; g++) begin
        check_cycle("hold", prev_segs, prev_errm, prev_word);
        chk("hold.pending", 32'(pending), 32'(1));
        step();
      end
      blank_lz = vecs[v].lz;
      chk("commit.pending", 32'(pending), 32'(0));
      for (int i = 0; i < FRAME; i++) begin
        check_cycle($sformatf("vec%0d", v), vecs[v].segs, vecs[v].errm, vecs[v].value);
        step();
      end
      prev_segs = vecs[v].segs; prev_errm = vecs[v].errm; prev_word = vecs[v].value;
    end

    // Load on the boundary edge commits directly; a load one cycle later waits a frame.
    for (int g = 0; g < FRAME && (k % FRAME) != 23; g++) begin
      check_cycle("pre_b", prev_segs, prev_errm, prev_word);
      step();
    end
    check_cycle("pre_b", prev_segs, prev_errm, prev_word);
    blank_lz = 1'b0;
    load = 1'b1; value = 16'h4321;
    step();
    chk("bnd.pending", 32'(pending), 32'(0));
    check_cycle("f4321", s4321, 4'b0000, 16'h4321);
    value = 16'h9999;
    step();
    load = 1'b0;
    for (int g = 0; g < FRAME && (k % FRAME) != 0; g++) begin
      check_cycle("f4321", s4321, 4'b0000, 16'h4321);
      chk("f4321.pending", 32'(pending), 32'(1));
      step();
    end
    chk("c9999.pending", 32'(pending), 32'(0));
    for (int i = 0; i < FRAME; i++) begin
      check_cycle("f9999", s9999, 4'b0000, 16'h9999);
      step();
    end

    // Reset in SHOW of digit 2 with a load pending.
    for (int g = 0; g < FRAME && (k % FRAME) != 10; g++) begin
      check_cycle("f9999", s9999, 4'b0000, 16'h9999);
      step();
    end
    load = 1'b1; value = 16'h5555;
    step();
    load = 1'b0;
    chk("pre_rst.pending", 32'(pending), 32'(1));
    for (int g = 0; g < FRAME && (k % FRAME) != 15; g++) begin
      check_cycle("pre_rst", s9999, 4'b0000, 16'h9999);
      step();
    end
    check_cycle("pre_rst", s9999, 4'b0000, 16'h9999);
    rst = 1'b1;
    #1;
    chk("async_rst.an", 32'(an), 32'(0));
    chk("async_rst.seg", 32'(seg), 32'(0));
    chk("async_rst.pending", 32'(pending), 32'(0));
    chk("async_rst.bcd", 32'(bcd), 32'(0));
    chk("async_rst.bcd_err", 32'(bcd_err), 32'(0));
    #2;
    rst = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      check_cycle("post_rst", zeros, 4'b0000, 16'h0000);
      chk("post_rst.pending", 32'(pending), 32'(0));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_display_scanner.md
# seg_display_scanner

Time-multiplexed display controller that shares one external combinational BCD-to-7-segment decoder across `NUM_DIGITS` common-anode-select digits. It holds a double-buffered BCD word and scans it one digit at a time. It inserts blanking gaps between digits to prevent ghosting, and commits newly loaded values only at frame boundaries. It sits between the numeric datapath (counters, measurement logic) and the board's segment and digit-enable pins.

## Interface

- `NUM_DIGITS`, 4 — digits scanned; ≥1.
- `REFRESH_DIV`, 1000 — clock cycles each digit is shown; ≥1.
- `BLANK_CYCLES`, 2 — all-off cycles before each digit is shown; ≥1.
- `clk` in 1 — single clock, all state on rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `load` in 1 — one-cycle strobe; capture `value`.
- `value` in 4*NUM_DIGITS — BCD digits; digit i = `value[4i+3:4i]`, digit 0 least significant.
- `blank_lz` in 1 — enables leading-zero blanking; sampled live.
- `bcd` out 4 — digit code to the shared decoder (combinational from active buffer and index).
- `segment_in` in 7 — decoder result, order abcdefg, 1 = lit.
- `seg` out 7 — registered segment drive, 1 = lit.
- `an` out NUM_DIGITS — registered one-hot digit enable, 1 = on.
- `pending` out 1 — shadow holds an uncommitted value.
- `frame_done` out 1 — one-cycle pulse at each frame boundary.
- `bcd_err` out 1 — registered; high while the shown digit code is >9.

## Operation

- Registers:
  - `active` (displayed word).
  - `shadow`.
  - `pending`.
  - digit index `idx` (0..NUM_DIGITS-1).
  - cycle counter, width `$clog2(max(REFRESH_DIV, BLANK_CYCLES)+1)`.
  - state.
- States:
  - BLANK: `an`=0, `seg`=0. Lasts BLANK_CYCLES cycles, then goes to SHOW. Counter resets on every state change.
  - SHOW: `an`=onehot(`idx`), `seg`=digit segments. Lasts REFRESH_DIV cycles, then goes to BLANK.
  - On SHOW→BLANK, `idx` increments. It wraps from NUM_DIGITS-1 to 0; that wrap is the frame boundary.
- `bcd` = `active[4*idx+3:4*idx]` in both states, so the decoder has settled before SHOW is entered.
- Segment selection, registered on entry to SHOW and refreshed every SHOW cycle:
  - Digit code >9: `seg`=7'b1001111 ('E'), `bcd_err`=1. The decoder output is ignored.
  - Else, if `blank_lz`=1, idx>0, and digit idx and every higher digit are 0: `seg`=0. `an` stays asserted.
  - Else: `seg`=`segment_in`.
  - Digit 0 is never blanked.
- Load and commit:
  - `load`: `shadow`←`value`, `pending`←1. A repeated load while pending overwrites; the last load wins.
  - Frame boundary with `pending`=1: `active`←`shadow`, `pending`←0.
  - `load` in the same cycle as a frame boundary: `active`←`value` directly, `pending` stays/becomes 0.
- `frame_done` pulses high for the one cycle after each frame boundary edge, regardless of commit.

## Timing

- Reset values:
  - `active`=0, `shadow`=0, `pending`=0, `idx`=0, state BLANK, counter 0.
  - `an`=0, `seg`=0, `bcd_err`=0, `frame_done`=0.
  - `bcd`=0 (follows `active`).
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronously); any pending load is discarded. After release, the first edge starts BLANK count 1.
- Digit period = BLANK_CYCLES+REFRESH_DIV cycles. Frame = NUM_DIGITS × digit period.
- `an` and `seg` change on the same edge. `an` is never non-zero on two consecutive digits without ≥BLANK_CYCLES cycles of all-zero between them.
- `load` → `pending`=1 on the next cycle. The new value appears on `bcd` on the cycle after the next frame boundary. Worst case is one frame plus one cycle.
- `segment_in` is sampled only in SHOW. Combinational path: `active`/`idx` → `bcd` → external decoder → `segment_in` → `seg` register.

## Test plan

Use NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2, with the standard decoder attached.

- Reset release, no load → 2 cycles `an`=0000/`seg`=0, then 4 cycles `an`=0001/`seg`=1111110. This repeats for `an`=0010/0100/1000 all showing "0". `frame_done` pulses every 24 cycles.
- load `value`=16'h1234 mid-frame → `pending`=1 next cycle. Display is unchanged until the wrap. The next frame shows digits 0..3 as 4,3,2,1 (0110011, 1111001, 1101101, 0110000). `pending`=0 after the commit.
- `blank_lz`=1, `value`=16'h0050 → digit0 shows 1111110, digit1 shows 1011011, digits 2 and 3 show `seg`=0 with `an` asserted.
- `value`=16'h00A7 → digit1 shows `seg`=1001111 with `bcd_err`=1. Other digits show normally with `bcd_err`=0.
- `load` coincident with the frame-boundary edge, then a second `load` of 16'h9999 one cycle later → the first value displays in the next frame. `pending`=1 with shadow 16'h9999, which commits one frame later.
- Assert `rst` during SHOW of digit 2 with `pending`=1 → `an`=0, `seg`=0, `pending`=0 immediately. After release the scan restarts at digit 0 showing "0".
